pipelined_csa_adder_param: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor. Successor to the fixed 28-bit sqrt-CSA datapath.

---
 rtl/csa_pkg.sv | 42 ++++
 rtl/csa_select_block.sv | 20 ++
 rtl/pipelined_csa_adder_param.sv | 130 +++++++++++++
 tb/tb_pipelined_csa_adder_param.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared constants, pipeline rank record and section-boundary helpers for the
// pipelined carry-select adder/subtractor.
package csa_pkg;

   localparam int MAX_W      = 64;
   localparam int DEF_WIDTH  = 28;
   localparam int DEF_STAGES = 2;
   localparam int DEF_BLK    = 4;
   localparam int NBLK       = (DEF_WIDTH + DEF_BLK - 1) / DEF_BLK;

   // Every rank has the same shape; low operand bits that a section has already
   // consumed are carried along unused and trimmed by synthesis.
   typedef struct packed {
      logic             valid;
      logic             carry;
      logic [MAX_W:0]   psum;
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;
   } rank_t;

   function automatic int num_blocks(input int width, input int blk);
      return (width + blk - 1) / blk;
   endfunction

   function automatic int section_lsb(input int k, input int width, input int stages, input int blk);
      int lsb;
      if (k >= stages) lsb = width;
      else             lsb = blk * ((k * num_blocks(width, blk)) / stages);
      return lsb;
   endfunction

   function automatic int block_section(input int j, input int width, input int stages, input int blk);
      int sec;
      sec = 0;
      for (int k = 1; k < stages; k++) begin
         if (j * blk >= section_lsb(k, width, stages, blk)) sec = k;
         else                                               sec = sec;
      end
      return sec;
   endfunction

endpackage

// File: rtl/csa_select_block.sv
// One carry-select block: both carry-in hypotheses are summed in parallel and
// the real carry-in picks the result.
module csa_select_block #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] sum0_s;
   logic [W:0] sum1_s;

   assign sum0_s      = {1'b0, a} + {1'b0, b};
   assign sum1_s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
   assign {cout, sum} = cin ? sum1_s : sum0_s;

endmodule

// File: rtl/pipelined_csa_adder_param.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control and bubble collapse.
// Optional signed-overflow output is built when CSA_OVF_EN is defined.
module pipelined_csa_adder_param
   import csa_pkg::*;
#(
   parameter int WIDTH  = 28,
   parameter int STAGES = 2,
   parameter int BLK    = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum
`ifdef CSA_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int NB = num_blocks(WIDTH, BLK);

   rank_t            rank_r [STAGES+1];
   rank_t            next_s [STAGES];
   rank_t            in_s;
   logic [STAGES:0]  free_s;
   logic [WIDTH-1:0] bsum_s;
   logic [NB-1:0]    cout_s;

   // A rank can load when out_ready is high or any rank from it onward is empty.
   always_comb begin
      logic hole;
      free_s = '0;
      for (int r = 0; r <= STAGES; r++) begin
         hole = 1'b0;
         for (int q = r; q <= STAGES; q++) hole = hole | ~rank_r[q].valid;
         free_s[r] = hole | out_ready;
      end
   end

   assign in_ready = free_s[0];

   // Subtraction folds into addition of ~b with the inverted borrow.
   always_comb begin
      in_s                  = '0;
      in_s.valid            = in_valid;
      in_s.carry            = c_in ^ sub;
      in_s.a[WIDTH-1:0]     = a;
      in_s.b[WIDTH-1:0]     = sub ? ~b : b;
   end

   for (genvar j = 0; j < NB; j++) begin : g_blk
      localparam int LO    = j * BLK;
      localparam int HI    = (LO + BLK < WIDTH) ? LO + BLK : WIDTH;
      localparam int SEC   = block_section(j, WIDTH, STAGES, BLK);
      localparam bit FIRST = (LO == section_lsb(SEC, WIDTH, STAGES, BLK));
      logic cin_s;

      // The first block of a section takes the carry registered by the previous rank.
      if (FIRST) begin : g_first
         assign cin_s = rank_r[SEC].carry;
      end else begin : g_chain
         assign cin_s = cout_s[j-1];
      end

      csa_select_block #(.W(HI - LO)) u_blk (
         .a    (rank_r[SEC].a[HI-1:LO]),
         .b    (rank_r[SEC].b[HI-1:LO]),
         .cin  (cin_s),
         .sum  (bsum_s[HI-1:LO]),
         .cout (cout_s[j])
      );
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_sec
      localparam int LO    = section_lsb(k, WIDTH, STAGES, BLK);
      localparam int HI    = section_lsb(k + 1, WIDTH, STAGES, BLK);
      localparam int LASTB = (HI + BLK - 1) / BLK - 1;
      rank_t nxt_s;

      // Merge this section's slice into the record headed for the next rank.
      always_comb begin
         nxt_s                = rank_r[k];
         nxt_s.psum[HI-1:LO]  = bsum_s[HI-1:LO];
         nxt_s.carry          = cout_s[LASTB];
         if (k == STAGES - 1) nxt_s.psum[WIDTH] = cout_s[LASTB];
         else                 nxt_s.psum[WIDTH] = rank_r[k].psum[WIDTH];
      end

      assign next_s[k] = nxt_s;
   end

   // Rank registers: hold when blocked, otherwise shift forward.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r <= STAGES; r++) rank_r[r] <= '0;
      end else begin
         if (free_s[0]) rank_r[0] <= in_s;
         for (int r = 1; r <= STAGES; r++) begin
            if (free_s[r]) rank_r[r] <= next_s[r-1];
         end
      end
   end

   assign out_valid = rank_r[STAGES].valid;
   assign sum       = rank_r[STAGES].psum[WIDTH:0];

`ifdef CSA_OVF_EN
   logic ovf_s;
   logic ovf_r;

   assign ovf_s = (next_s[STAGES-1].a[WIDTH-1] == next_s[STAGES-1].b[WIDTH-1]) &&
                  (next_s[STAGES-1].psum[WIDTH-1] != next_s[STAGES-1].a[WIDTH-1]);

   // Overflow flag travels with the output rank.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)               ovf_r <= 1'b0;
      else if (free_s[STAGES]) ovf_r <= ovf_s;
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipelined_csa_adder_param.sv
// Randomised self-checking bench for pipelined_csa_adder_param (28-bit/2-stage and 13-bit/3-stage builds).
module tb_pipelined_csa_adder_param;

   localparam int W  = 28;
   localparam int S  = 2;
   localparam int B  = 4;
   localparam int W2 = 13;
   localparam int S2 = 3;

   logic          clk;
   logic          rstn;
   logic          in_valid, in_ready, c_in, sub, out_valid, out_ready;
   logic [W-1:0]  a, b;
   logic [W:0]    sum;
   logic          in_valid2, in_ready2, c_in2, sub2, out_valid2, out_ready2;
   logic [W2-1:0] a2, b2;
   logic [W2:0]   sum2;
`ifdef CSA_OVF_EN
   logic          ovf, ovf2;
   logic          exp_ovf_q[$];
   logic          got_ovf_q[$];
`endif

   int            errors;
   int            checks;
   logic [W:0]    exp_q[$];
   logic [W:0]    got_q[$];
   logic [31:0]   rnd;

   pipelined_csa_adder_param #(.WIDTH(W), .STAGES(S), .BLK(B)) dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum)
`ifdef CSA_OVF_EN
      , .ovf(ovf)
`endif
   );

   pipelined_csa_adder_param #(.WIDTH(W2), .STAGES(S2), .BLK(B)) dut13 (
      .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .c_in(c_in2), .sub(sub2),
      .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2)
`ifdef CSA_OVF_EN
      , .ovf(ovf2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Reference: a - b - c_in is biased by 2^W so the carry-out bit reads 1 for "no borrow".
   function automatic logic [W:0] model_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic c, input logic s);
      longint unsigned t;
      if (s) t = longint'(x) + (64'd1 << W) - longint'(y) - longint'(c);
      else   t = longint'(x) + longint'(y) + longint'(c);
      return t[W:0];
   endfunction

   // Reference: signed overflow means the true signed result leaves the W-bit range.
   function automatic logic model_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                      input logic c, input logic s);
      longint sx, sy, r;
      sx = longint'(x);
      if (x[W-1]) sx = sx - (longint'(1) << W);
      sy = longint'(y);
      if (y[W-1]) sy = sy - (longint'(1) << W);
      r = s ? (sx - sy - longint'(c)) : (sx + sy + longint'(c));
      return (r > ((longint'(1) << (W - 1)) - 1)) || (r < -(longint'(1) << (W - 1)));
   endfunction

   task automatic clear_q();
      exp_q.delete();
      got_q.delete();
`ifdef CSA_OVF_EN
      exp_ovf_q.delete();
      got_ovf_q.delete();
`endif
   endtask

   // One clock: log transfers seen just before the edge, then step past it.
   task automatic tick();
      #1;
      if (in_valid && in_ready) begin
         exp_q.push_back(model_sum(a, b, c_in, sub));
`ifdef CSA_OVF_EN
         exp_ovf_q.push_back(model_ovf(a, b, c_in, sub));
`endif
      end
      if (out_valid && out_ready) begin
         got_q.push_back(sum);
`ifdef CSA_OVF_EN
         got_ovf_q.push_back(ovf);
`endif
      end
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ops();
      rnd = $urandom(); a = rnd[W-1:0];
      rnd = $urandom(); b = rnd[W-1:0];
      if ($urandom_range(0, 7) == 0) a = '1;
      if ($urandom_range(0, 7) == 0) b = '0;
      c_in = 1'($urandom_range(0, 1));
      sub  = 1'($urandom_range(0, 1));
   endtask

   task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s,
                          output logic [W:0] res, output logic res_ovf, output bit ok);
      clear_q();
      a = x; b = y; c_in = c; sub = s; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      ok = (exp_q.size() == 1);
      for (int i = 0; i < 8 && got_q.size() == 0; i++) tick();
      ok      = ok && (got_q.size() == 1);
      res     = (got_q.size() > 0) ? got_q[0] : '0;
      res_ovf = 1'b0;
`ifdef CSA_OVF_EN
      res_ovf = (got_ovf_q.size() > 0) ? got_ovf_q[0] : 1'b0;
`endif
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; c_in2 = 1'b0; sub2 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (sum !== '0) begin errors++; $display("FAIL reset_sum got=%h exp=0", sum); end
      checks++; if (out_valid2 !== 1'b0) begin errors++; $display("FAIL reset_out_valid13 got=%b exp=0", out_valid2); end
      rstn = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL post_reset got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
      end
   endtask

   task automatic test_add_basic();
      clear_q();
      a = 28'h0FFFFFF; b = 28'h0000001; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      checks++; if (exp_q.size() != 1) begin errors++; $display("FAIL add_accept got=%0d exp=1", exp_q.size()); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_lat_e1 got=%b exp=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_lat_e2 got=%b exp=0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1 || sum !== 29'h01000000) begin
         errors++; $display("FAIL add_basic got valid=%b sum=%h exp valid=1 sum=01000000", out_valid, sum);
      end
      tick();
   endtask

   task automatic test_carry_and_sub();
      logic [W:0] r;
      logic       o;
      bit         ok;
      run_one(28'hFFFFFFF, 28'h0000000, 1'b1, 1'b0, r, o, ok);
      checks++; if (!ok || r !== 29'h10000000) begin errors++; $display("FAIL ripple got=%h ok=%0d exp=10000000", r, ok); end
      run_one(28'hFFFFFFF, 28'h0000001, 1'b1, 1'b0, r, o, ok);
      checks++; if (!ok || r !== 29'h10000001) begin errors++; $display("FAIL ripple2 got=%h ok=%0d exp=10000001", r, ok); end
      run_one(28'd5, 28'd7, 1'b0, 1'b1, r, o, ok);
      checks++; if (!ok || r !== 29'h0FFFFFFE) begin errors++; $display("FAIL sub_neg got=%h ok=%0d exp=0FFFFFFE", r, ok); end
      run_one(28'd7, 28'd5, 1'b0, 1'b1, r, o, ok);
      checks++; if (!ok || r !== 29'h10000002) begin errors++; $display("FAIL sub_pos got=%h ok=%0d exp=10000002", r, ok); end
      run_one(28'd7, 28'd5, 1'b1, 1'b1, r, o, ok);
      checks++; if (!ok || r !== 29'h10000001) begin errors++; $display("FAIL sub_borrow got=%h ok=%0d exp=10000001", r, ok); end
   endtask

   task automatic test_random_stream();
      clear_q();
      for (int cyc = 0; cyc < 80; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         rand_ops();
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) tick();
      checks++; if (got_q.size() != exp_q.size()) begin
         errors++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL rand_sum idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
`ifdef CSA_OVF_EN
         checks++; if (got_ovf_q[i] !== exp_ovf_q[i]) begin
            errors++; $display("FAIL rand_ovf idx=%0d got=%b exp=%b", i, got_ovf_q[i], exp_ovf_q[i]);
         end
`endif
      end
   endtask

   task automatic test_backpressure();
      logic [W:0] held;
      bit         have_held, saw_drop;
      int         inflight;
      logic       exp_rdy;
      clear_q();
      have_held = 1'b0; saw_drop = 1'b0; held = '0;
      for (int cyc = 0; cyc < 40 && got_q.size() < 10; cyc++) begin
         in_valid = (exp_q.size() < 10);
         rand_ops();
         out_ready = !(cyc >= 4 && cyc < 9);
         #1;
         inflight = exp_q.size() - got_q.size();
         exp_rdy  = out_ready || (inflight < S + 1);
         checks++; if (in_ready !== exp_rdy) begin
            errors++; $display("FAIL bp_in_ready cyc=%0d inflight=%0d got=%b exp=%b", cyc, inflight, in_ready, exp_rdy);
         end
         if (!in_ready) saw_drop = 1'b1;
         if (!out_ready) begin
            if (have_held) begin
               checks++; if (out_valid !== 1'b1 || sum !== held) begin
                  errors++; $display("FAIL bp_hold cyc=%0d got valid=%b sum=%h exp valid=1 sum=%h", cyc, out_valid, sum, held);
               end
            end else if (out_valid) begin
               held = sum; have_held = 1'b1;
            end
         end
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (!saw_drop) begin errors++; $display("FAIL bp_drop got=0 exp=1"); end
      checks++; if (got_q.size() != 10 || exp_q.size() != 10) begin
         errors++; $display("FAIL bp_count got=%0d sent=%0d exp=10", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      logic [W:0] r;
      logic       o;
      bit         ok;
      clear_q();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         rand_ops();
         tick();
      end
      in_valid = 1'b0;
      checks++; if (exp_q.size() != 3 || out_valid !== 1'b1) begin
         errors++; $display("FAIL mid_fill got accepted=%0d valid=%b exp 3/1", exp_q.size(), out_valid);
      end
      #1 rstn = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || sum !== '0) begin
         errors++; $display("FAIL mid_async got valid=%b sum=%h exp 0/0", out_valid, sum);
      end
      #1 rstn = 1'b1;
      out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
      clear_q();
      repeat (4) tick();
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mid_stale got=%0d exp=0", got_q.size()); end
      run_one(28'h1234567, 28'h0ABCDEF, 1'b1, 1'b0, r, o, ok);
      checks++; if (!ok || r !== model_sum(28'h1234567, 28'h0ABCDEF, 1'b1, 1'b0)) begin
         errors++; $display("FAIL mid_next got=%h ok=%0d exp=%h", r, ok, model_sum(28'h1234567, 28'h0ABCDEF, 1'b1, 1'b0));
      end
   endtask

   task automatic test_width13();
      localparam int N = 12;
      logic [W2:0] exp2 [N];
      longint unsigned t;
      bit exp_v;
      for (int t_i = 0; t_i < N + S2 + 1; t_i++) begin
         if (t_i < N) begin
            in_valid2 = 1'b1;
            if (t_i == 0) begin a2 = 13'h1FFF; b2 = 13'h0000; c_in2 = 1'b1; sub2 = 1'b0; end
            else if (t_i == 1) begin a2 = 13'h1FFF; b2 = 13'h1FFF; c_in2 = 1'b1; sub2 = 1'b0; end
            else begin
               rnd = $urandom(); a2 = rnd[W2-1:0];
               rnd = $urandom(); b2 = rnd[W2-1:0];
               c_in2 = 1'($urandom_range(0, 1)); sub2 = 1'($urandom_range(0, 1));
            end
            if (sub2) t = longint'(a2) + (64'd1 << W2) - longint'(b2) - longint'(c_in2);
            else      t = longint'(a2) + longint'(b2) + longint'(c_in2);
            exp2[t_i] = t[W2:0];
         end else begin
            in_valid2 = 1'b0;
         end
         out_ready2 = 1'b1;
         @(posedge clk);
         #1;
         exp_v = (t_i >= S2) && (t_i - S2 < N);
         checks++; if (out_valid2 !== exp_v || in_ready2 !== 1'b1) begin
            errors++; $display("FAIL w13_valid t=%0d got valid=%b rdy=%b exp valid=%b rdy=1", t_i, out_valid2, in_ready2, exp_v);
         end
         if (exp_v) begin
            checks++; if (sum2 !== exp2[t_i-S2]) begin
               errors++; $display("FAIL w13_sum t=%0d got=%h exp=%h", t_i, sum2, exp2[t_i-S2]);
            end
         end
      end
      checks++; if (exp2[0] !== 14'h2000 || exp2[1] !== 14'h3FFF) begin
         errors++; $display("FAIL w13_model got=%h/%h exp=2000/3fff", exp2[0], exp2[1]);
      end
   endtask

`ifdef CSA_OVF_EN
   task automatic test_ovf();
      logic [W:0] r;
      logic       o;
      bit         ok;
      run_one(28'h7FFFFFF, 28'h0000001, 1'b0, 1'b0, r, o, ok);
      checks++; if (!ok || o !== 1'b1) begin errors++; $display("FAIL ovf_add got=%b ok=%0d exp=1", o, ok); end
      run_one(28'h8000000, 28'h0000001, 1'b0, 1'b1, r, o, ok);
      checks++; if (!ok || o !== 1'b1) begin errors++; $display("FAIL ovf_sub got=%b ok=%0d exp=1", o, ok); end
      run_one(28'd3, 28'd4, 1'b0, 1'b0, r, o, ok);
      checks++; if (!ok || o !== 1'b0) begin errors++; $display("FAIL ovf_none got=%b ok=%0d exp=0", o, ok); end
   endtask
`endif

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_add_basic();
      test_carry_and_sub();
      test_random_stream();
      test_backpressure();
      test_reset_midflight();
      test_width13();
`ifdef CSA_OVF_EN
      test_ovf();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
